// File: rtl/tx_status_pkg.sv
// Shared constants for the TX-status record queue: default geometry, register map,
// status-word field offsets and the empty-queue marker returned on word 0.
package tx_status_pkg;

  localparam int NUM_WORDS_DEF = 8;
  localparam int DEPTH_DEF     = 64;
  localparam int ADDR_W_DEF    = 5;

  localparam logic [4:0]  BASE_ADDR_DEF   = 5'h16;
  localparam logic [4:0]  STATUS_ADDR_DEF = 5'h1f;
  localparam logic [31:0] W0_EMPTY_DEF    = 32'hFFFF_FFFF;

  // status word = {drop_cnt[15:0], 7'd0, full, occupancy[7:0]}
  localparam int STAT_OCC_LSB  = 0;
  localparam int STAT_FULL_BIT = 8;
  localparam int STAT_DROP_LSB = 16;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/tx_status_ram.sv
// Record storage: one synchronous write port, one asynchronous read port.
// Read data follows rd_addr combinationally; no backpressure, writes always land.
module tx_status_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/tx_status_record_fifo.sv
// Multi-word TX-status queue popped atomically over the register window; push lands 2 edges after rec_valid.
// No backpressure: pushes into a full queue (with no same-cycle pop) are dropped and counted.
module tx_status_record_fifo
  import tx_status_pkg::*;
#(
  parameter int                NUM_WORDS   = NUM_WORDS_DEF,
  parameter int                DEPTH       = DEPTH_DEF,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(BASE_ADDR_DEF),
  parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_ADDR_DEF),
  parameter logic [31:0]       W0_EMPTY    = W0_EMPTY_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rec_valid,
  input  logic [NUM_WORDS*32-1:0] rec_data,
  input  logic                    flush,
  input  logic                    slv_reg_rden,
  input  logic [ADDR_W-1:0]       axi_araddr_core,
  output logic [NUM_WORDS*32-1:0] rec_out,
  output logic [31:0]             status_out,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int REC_W = NUM_WORDS * 32;

  logic             in_vld;
  logic [REC_W-1:0] in_dat;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [REC_W-1:0] head;
  logic [REC_W-1:32] snap;
  logic             snap_valid;
  logic [15:0]      drop_cnt;

  logic word0_rd;
  logic status_rd;
  logic pop;
  logic push;
  logic accept;
  logic drop;

  assign empty     = (occ == '0);
  assign full      = (occ == OCC_W'(DEPTH));
  assign word0_rd  = slv_reg_rden && (axi_araddr_core == BASE_ADDR);
  assign status_rd = slv_reg_rden && (axi_araddr_core == STATUS_ADDR);
  assign pop       = word0_rd && !empty && !flush;
  assign push      = in_vld && !flush;
  // A same-cycle pop frees the head slot, so a push into a full queue still fits.
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_vld <= 1'b0;
      in_dat <= '0;
    end else begin
      in_vld <= rec_valid && !flush;
      if (rec_valid) in_dat <= rec_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      occ    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end else if (flush) begin
      snap_valid <= 1'b0;
    end else if (pop) begin
      snap       <= head[REC_W-1:32];
      snap_valid <= 1'b1;
    end else if (word0_rd) begin
      snap_valid <= 1'b0;
    end
  end

  // A drop coinciding with the clearing read must survive as the first new count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (status_rd) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  tx_status_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W),
    .AW    (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_dat  (in_dat),
    .rd_addr (rd_ptr),
    .rd_dat  (head)
  );

  always_comb begin
    rec_out          = '0;
    if (snap_valid) rec_out[REC_W-1:32] = snap;
    rec_out[31:0]    = empty ? W0_EMPTY : head[31:0];
  end

  always_comb begin
    status_out                         = '0;
    status_out[STAT_DROP_LSB +: 16]    = drop_cnt;
    status_out[STAT_FULL_BIT]          = full;
    status_out[STAT_OCC_LSB +: 8]      = 8'(occ);
  end

endmodule
